// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive FIFO with per-byte error flags, overrun tracking,
// character timeout and prioritised receive interrupt for the CPU side.
//
// state    | meaning
// TO_IDLE  | not timing: FIFO empty, or a push/pop was just seen
// TO_COUNT | counting tick_16x periods since the last FIFO activity
// TO_FIRED | character timeout asserted until activity or FIFO empty
module uart_rx_ctrl #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int TO_TICKS = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_16x,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  input  logic          rx_frame_err,
  input  logic          rx_parity_err,
  input  logic          rd_en,
  input  logic          lsr_rd,
  input  logic          fifo_clr,
  input  logic [1:0]    trig_lvl,
  input  logic          ie_rls,
  input  logic          ie_rda,
  output logic [7:0]    rd_data,
  output logic          head_ferr,
  output logic          head_perr,
  output logic          data_ready,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          err_in_fifo,
  output logic          rx_timeout,
  output logic          irq,
  output logic [1:0]    irq_id
);

  localparam int CW = $clog2(TO_TICKS + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    TO_IDLE  = 2'd0,
    TO_COUNT = 2'd1,
    TO_FIRED = 2'd2
  } to_state_t;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_q, err_cnt;
  logic          ovr_q;
  to_state_t     to_state, to_state_nxt;
  logic [CW-1:0] to_cnt, to_cnt_nxt;
  logic [1:0]    irq_id_q, irq_id_nxt;
  logic [9:0]    head;
  logic [AW:0]   trig_thr;
  logic          not_empty, full, pop_ok, push_ok, ovr_evt;
  logic          push_flag, pop_flag, activity, rls_cond, rda_cond;

  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == FULL_CNT);
  assign pop_ok    = rd_en && not_empty && !fifo_clr;
  // A pop at full frees the slot the push lands in, so no overrun then.
  assign push_ok   = rx_done && (!full || pop_ok) && !fifo_clr;
  assign ovr_evt   = rx_done && full && !pop_ok && !fifo_clr;
  assign head      = not_empty ? mem[rd_ptr] : '0;
  assign push_flag = push_ok && (rx_frame_err || rx_parity_err);
  assign pop_flag  = pop_ok && (head[8] || head[9]);
  assign activity  = push_ok || pop_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {rx_parity_err, rx_frame_err, rx_data};
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      err_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      case ({push_flag, pop_flag})
        2'b10:   err_cnt <= err_cnt + (AW+1)'(1);
        2'b01:   err_cnt <= err_cnt - (AW+1)'(1);
        default: err_cnt <= err_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ovr_q <= 1'b0;
    else if (ovr_evt) ovr_q <= 1'b1;
    else if (lsr_rd)  ovr_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_state <= TO_IDLE;
      to_cnt   <= '0;
    end else begin
      to_state <= to_state_nxt;
      to_cnt   <= to_cnt_nxt;
    end
  end

  always_comb begin
    to_state_nxt = to_state;
    to_cnt_nxt   = to_cnt;
    case (to_state)
      TO_IDLE: begin
        if (!activity && tick_16x && not_empty) begin
          to_state_nxt = TO_COUNT;
          to_cnt_nxt   = '0;
        end
      end
      TO_COUNT: begin
        if (activity) begin
          to_state_nxt = TO_IDLE;
          to_cnt_nxt   = '0;
        end else if (tick_16x) begin
          if (to_cnt >= CW'(TO_TICKS - 2)) begin
            to_state_nxt = TO_FIRED;
            to_cnt_nxt   = CW'(TO_TICKS - 1);
          end else begin
            to_cnt_nxt = to_cnt + CW'(1);
          end
        end
      end
      TO_FIRED: begin
        if (activity || !not_empty) begin
          to_state_nxt = TO_IDLE;
          to_cnt_nxt   = '0;
        end
      end
      default: begin
        to_state_nxt = TO_IDLE;
        to_cnt_nxt   = '0;
      end
    endcase
    if (fifo_clr) begin
      to_state_nxt = TO_IDLE;
      to_cnt_nxt   = '0;
    end
  end

  always_comb begin
    rx_timeout = (to_state == TO_FIRED);
  end

  always_comb begin
    case (trig_lvl)
      2'd0:    trig_thr = (AW+1)'(1);
      2'd1:    trig_thr = (AW+1)'(DEPTH / 4);
      2'd2:    trig_thr = (AW+1)'(DEPTH / 2);
      default: trig_thr = (AW+1)'(DEPTH - 2);
    endcase
    rls_cond = ovr_q || head[8] || head[9];
    rda_cond = (cnt_q >= trig_thr);
    if (ie_rls && rls_cond)        irq_id_nxt = 2'b11;
    else if (ie_rda && rda_cond)   irq_id_nxt = 2'b10;
    else if (ie_rda && rx_timeout) irq_id_nxt = 2'b01;
    else                           irq_id_nxt = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) irq_id_q <= 2'b00;
    else     irq_id_q <= irq_id_nxt;
  end

  assign rd_data     = head[7:0];
  assign head_ferr   = head[8];
  assign head_perr   = head[9];
  assign data_ready  = not_empty;
  assign count       = cnt_q;
  assign overrun     = ovr_q;
  assign err_in_fifo = (err_cnt != '0);
  assign irq_id      = irq_id_q;
  assign irq         = (irq_id_q != 2'b00);

endmodule
